// File: rtl/cas_ram_if.sv
// Bus bundle between the CAS image arbiter and its neighbours: the downloader,
// the tape player read port and the single-port image RAM.
interface cas_ram_if #(
    parameter int AW = 18
);
    logic          dl_active;
    logic          dl_wr;
    logic [AW-1:0] dl_addr;
    logic [7:0]    dl_data;
    logic          dl_wait;
    logic          dl_done;
    logic          dl_overflow;

    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_ack;
    logic [7:0]    rd_data;
    logic          rd_eof;

    logic [AW:0]   cas_len;
    logic          cas_valid;

    logic [AW-1:0] ram_addr;
    logic          ram_wren;
    logic [7:0]    ram_data;
    logic [7:0]    ram_q;

    modport slave (
        input  dl_active, dl_wr, dl_addr, dl_data, rd_req, rd_addr, ram_q,
        output dl_wait, dl_done, dl_overflow, rd_ack, rd_data, rd_eof,
               cas_len, cas_valid, ram_addr, ram_wren, ram_data
    );

    modport master (
        output dl_active, dl_wr, dl_addr, dl_data, rd_req, rd_addr, ram_q,
        input  dl_wait, dl_done, dl_overflow, rd_ack, rd_data, rd_eof,
               cas_len, cas_valid, ram_addr, ram_wren, ram_data
    );
endinterface

// File: rtl/cas_ram_arbiter.sv
// Serialises downloader writes and tape-player reads onto the single-port
// cassette image RAM, tracking the committed image length.
module cas_ram_arbiter #(
    parameter int AW         = 18,
    parameter int RD_LATENCY = 1
) (
    input  logic      clk,
    input  logic      reset,
    cas_ram_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_e;

    state_e        state_q,       state_d;
    logic          hold_full_q,   hold_full_d;
    logic [AW-1:0] hold_addr_q,   hold_addr_d;
    logic [7:0]    hold_data_q,   hold_data_d;
    logic          dl_overflow_q, dl_overflow_d;
    logic          dl_done_q,     dl_done_d;
    logic          dl_active_q,   dl_active_d;
    logic          commit_arm_q,  commit_arm_d;
    logic [AW:0]   cas_len_q,     cas_len_d;
    logic          cas_valid_q,   cas_valid_d;
    logic          rd_ack_q,      rd_ack_d;
    logic          rd_eof_q,      rd_eof_d;
    logic [7:0]    rd_data_q,     rd_data_d;
    logic [AW-1:0] ram_addr_q,    ram_addr_d;
    logic          ram_wren_q,    ram_wren_d;
    logic [7:0]    ram_data_q,    ram_data_d;
    logic [1:0]    lat_cnt_q,     lat_cnt_d;

    logic          dl_rise, dl_fall;
    logic [AW:0]   wr_len;

    assign dl_rise = bus.dl_active & ~dl_active_q;
    assign dl_fall = ~bus.dl_active & dl_active_q;
    // Length after committing the held byte; one extra bit so the top address cannot wrap.
    assign wr_len  = {1'b0, hold_addr_q} + {{AW{1'b0}}, 1'b1};

    always_comb begin
        state_d       = state_q;
        hold_full_d   = hold_full_q;
        hold_addr_d   = hold_addr_q;
        hold_data_d   = hold_data_q;
        dl_overflow_d = dl_overflow_q;
        dl_done_d     = 1'b0;
        dl_active_d   = bus.dl_active;
        commit_arm_d  = commit_arm_q;
        cas_len_d     = cas_len_q;
        cas_valid_d   = cas_valid_q;
        rd_ack_d      = 1'b0;
        rd_eof_d      = 1'b0;
        rd_data_d     = rd_data_q;
        ram_addr_d    = ram_addr_q;
        ram_wren_d    = 1'b0;
        ram_data_d    = ram_data_q;
        lat_cnt_d     = lat_cnt_q;

        if (bus.dl_wr) begin
            if (hold_full_q) begin
                dl_overflow_d = 1'b1;
            end else begin
                hold_full_d = 1'b1;
                hold_addr_d = bus.dl_addr;
                hold_data_d = bus.dl_data;
            end
        end

        if (dl_fall) commit_arm_d = 1'b1;
        if (dl_rise) begin
            cas_len_d    = '0;
            cas_valid_d  = 1'b0;
            commit_arm_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    state_d     = WRITE;
                    ram_addr_d  = hold_addr_q;
                    ram_data_d  = hold_data_q;
                    ram_wren_d  = 1'b1;
                    hold_full_d = 1'b0;
                    if (!dl_rise && wr_len > cas_len_q) cas_len_d = wr_len;
                end else if (commit_arm_q && !bus.dl_active) begin
                    state_d      = DONE;
                    cas_valid_d  = 1'b1;
                    dl_done_d    = 1'b1;
                    commit_arm_d = 1'b0;
                end else if (bus.rd_req && !rd_ack_q && !bus.dl_active && !dl_fall) begin
                    // Past-the-end reads are answered locally without a RAM cycle.
                    if ({1'b0, bus.rd_addr} >= cas_len_q) begin
                        rd_ack_d  = 1'b1;
                        rd_eof_d  = 1'b1;
                        rd_data_d = 8'hFF;
                    end else begin
                        state_d    = READ;
                        ram_addr_d = bus.rd_addr;
                        lat_cnt_d  = 2'd0;
                    end
                end
            end
            READ: begin
                if (lat_cnt_q == 2'(RD_LATENCY)) begin
                    state_d   = IDLE;
                    rd_ack_d  = 1'b1;
                    rd_data_d = bus.ram_q;
                end else begin
                    lat_cnt_d = lat_cnt_q + 2'd1;
                end
            end
            WRITE:   state_d = IDLE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            hold_full_q   <= 1'b0;
            hold_addr_q   <= '0;
            hold_data_q   <= '0;
            dl_overflow_q <= 1'b0;
            dl_done_q     <= 1'b0;
            dl_active_q   <= 1'b0;
            commit_arm_q  <= 1'b0;
            cas_len_q     <= '0;
            cas_valid_q   <= 1'b0;
            rd_ack_q      <= 1'b0;
            rd_eof_q      <= 1'b0;
            rd_data_q     <= 8'h00;
            ram_addr_q    <= '0;
            ram_wren_q    <= 1'b0;
            ram_data_q    <= '0;
            lat_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            hold_full_q   <= hold_full_d;
            hold_addr_q   <= hold_addr_d;
            hold_data_q   <= hold_data_d;
            dl_overflow_q <= dl_overflow_d;
            dl_done_q     <= dl_done_d;
            dl_active_q   <= dl_active_d;
            commit_arm_q  <= commit_arm_d;
            cas_len_q     <= cas_len_d;
            cas_valid_q   <= cas_valid_d;
            rd_ack_q      <= rd_ack_d;
            rd_eof_q      <= rd_eof_d;
            rd_data_q     <= rd_data_d;
            ram_addr_q    <= ram_addr_d;
            ram_wren_q    <= ram_wren_d;
            ram_data_q    <= ram_data_d;
            lat_cnt_q     <= lat_cnt_d;
        end
    end

    assign bus.dl_wait     = hold_full_q;
    assign bus.dl_done     = dl_done_q;
    assign bus.dl_overflow = dl_overflow_q;
    assign bus.rd_ack      = rd_ack_q;
    assign bus.rd_eof      = rd_eof_q;
    assign bus.rd_data     = rd_data_q;
    assign bus.cas_len     = cas_len_q;
    assign bus.cas_valid   = cas_valid_q;
    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_wren    = ram_wren_q;
    assign bus.ram_data    = ram_data_q;
endmodule

// File: tb/tb_cas_ram_arbiter.sv
// Bench for cas_ram_arbiter: vector tables, hand-written corner sequences and
// randomized download/read traffic against an image-level reference model.
module tb_cas_ram_arbiter;
    localparam int AW = 18;

    typedef struct { logic [AW-1:0] addr; logic [7:0] data; } wr_vec_t;
    typedef struct { logic [AW-1:0] addr; logic exp_eof; logic [7:0] exp_data; int exp_lat; } rd_vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cas_ram_if #(.AW(AW)) bus ();
    cas_ram_arbiter #(.AW(AW), .RD_LATENCY(1)) dut (.clk(clk), .reset(reset), .bus(bus));

    // Single-port RAM with one cycle of read latency.
    logic [7:0] mem [0:(1<<AW)-1];
    initial for (int i = 0; i < (1<<AW); i++) mem[i] = 8'h00;
    always @(posedge clk) begin
        if (bus.ram_wren) mem[bus.ram_addr] <= bus.ram_data;
        bus.ram_q <= mem[bus.ram_addr];
    end

    // Observers.
    int n_chk = 0, n_fail = 0;
    int done_cnt = 0, ack_cnt = 0, wren_in_rd = 0;
    logic [AW+7:0] wren_q [$];
    always @(posedge clk) begin
        if (bus.dl_done) done_cnt++;
        if (bus.rd_ack) ack_cnt++;
        if (bus.ram_wren) wren_q.push_back({bus.ram_addr, bus.ram_data});
        if (bus.ram_wren && bus.rd_req) wren_in_rd++;
    end

    // Reference image: bytes ever written plus the current committed length.
    logic [7:0] ref_mem [int];
    int         ref_len = 0;

    function automatic logic [7:0] ref_byte(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start_dl;
        bus.dl_active = 1'b1;
        tick;
        ref_len = 0;
        chk("dl_start_len", 32'(bus.cas_len), 32'd0);
        chk("dl_start_valid", 32'(bus.cas_valid), 32'd0);
    endtask

    task automatic dl_write(input logic [AW-1:0] a, input logic [7:0] d);
        bus.dl_addr = a; bus.dl_data = d; bus.dl_wr = 1'b1;
        tick;
        bus.dl_wr = 1'b0;
        chk("dl_wait_hi", 32'(bus.dl_wait), 32'd1);
        tick;
        chk("dl_wait_lo", 32'(bus.dl_wait), 32'd0);
        ref_mem[int'(a)] = d;
        if (int'(a) + 1 > ref_len) ref_len = int'(a) + 1;
    endtask

    task automatic end_dl;
        int d0;
        bit seen;
        d0 = done_cnt;
        seen = 1'b0;
        bus.dl_active = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick;
            if (bus.dl_done) seen = 1'b1;
        end
        chk("dl_done_seen", 32'(seen), 32'd1);
        tick;
        chk("dl_done_once", 32'(done_cnt - d0), 32'd1);
        chk("cas_valid", 32'(bus.cas_valid), 32'd1);
        chk("cas_len", 32'(bus.cas_len), 32'(ref_len));
    endtask

    task automatic do_read(input logic [AW-1:0] a, output logic [7:0] d, output logic e, output int lat);
        bus.rd_addr = a; bus.rd_req = 1'b1;
        lat = 0; d = 8'h00; e = 1'b0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            tick;
            if (bus.rd_ack) begin lat = i; d = bus.rd_data; e = bus.rd_eof; end
        end
        bus.rd_req = 1'b0;
        if (lat == 0) chk("rd_timeout", 32'd0, 32'd1);
        tick;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_dl_wait"}, 32'(bus.dl_wait), 32'd0);
        chk({tag, "_dl_done"}, 32'(bus.dl_done), 32'd0);
        chk({tag, "_dl_overflow"}, 32'(bus.dl_overflow), 32'd0);
        chk({tag, "_rd_ack"}, 32'(bus.rd_ack), 32'd0);
        chk({tag, "_rd_data"}, 32'(bus.rd_data), 32'd0);
        chk({tag, "_rd_eof"}, 32'(bus.rd_eof), 32'd0);
        chk({tag, "_cas_len"}, 32'(bus.cas_len), 32'd0);
        chk({tag, "_cas_valid"}, 32'(bus.cas_valid), 32'd0);
        chk({tag, "_ram_addr"}, 32'(bus.ram_addr), 32'd0);
        chk({tag, "_ram_wren"}, 32'(bus.ram_wren), 32'd0);
        chk({tag, "_ram_data"}, 32'(bus.ram_data), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        wr_vec_t    wtab [4];
        rd_vec_t    rtab [5];
        logic [7:0] d;
        logic       e;
        int         lat, a0, d0;
        logic [AW+7:0] w;

        wtab[0] = '{18'h0, 8'hA0};
        wtab[1] = '{18'h1, 8'hA1};
        wtab[2] = '{18'h2, 8'hA2};
        wtab[3] = '{18'h3, 8'hA3};
        rtab[0] = '{18'h2, 1'b0, 8'hA2, 3};
        rtab[1] = '{18'h4, 1'b1, 8'hFF, 1};
        rtab[2] = '{18'h0, 1'b0, 8'hA0, 3};
        rtab[3] = '{18'h3, 1'b0, 8'hA3, 3};
        rtab[4] = '{18'h5, 1'b1, 8'hFF, 1};

        bus.dl_active = 1'b0; bus.dl_wr = 1'b0; bus.dl_addr = '0; bus.dl_data = '0;
        bus.rd_req = 1'b0; bus.rd_addr = '0;
        reset = 1'b1;
        repeat (3) tick;
        check_outputs_zero("reset");
        reset = 1'b0;
        tick;

        // Empty image: read is answered as EOF with no RAM write.
        do_read(18'h0, d, e, lat);
        chk("empty_lat", 32'(lat), 32'd1);
        chk("empty_eof", 32'(e), 32'd1);
        chk("empty_data", 32'(d), 32'hFF);
        chk("empty_no_wren", 32'(wren_q.size()), 32'd0);

        // Table-driven four-byte download.
        start_dl;
        wren_q.delete();
        foreach (wtab[i]) dl_write(wtab[i].addr, wtab[i].data);
        end_dl;
        chk("tab_wren_cnt", 32'(wren_q.size()), 32'd4);
        foreach (wtab[i]) begin
            if (wren_q.size() > 0) begin
                w = wren_q.pop_front();
                chk("tab_wren_addr", 32'(w[AW+7:8]), 32'(wtab[i].addr));
                chk("tab_wren_data", 32'(w[7:0]), 32'(wtab[i].data));
            end
        end
        foreach (rtab[i]) begin
            do_read(rtab[i].addr, d, e, lat);
            chk("tab_rd_lat", 32'(lat), 32'(rtab[i].exp_lat));
            chk("tab_rd_eof", 32'(e), 32'(rtab[i].exp_eof));
            chk("tab_rd_data", 32'(d), 32'(rtab[i].exp_data));
        end

        // Back-to-back strobes: second byte is dropped and overflow sticks.
        start_dl;
        wren_q.delete();
        bus.dl_addr = 18'd10; bus.dl_data = 8'h55; bus.dl_wr = 1'b1;
        tick;
        bus.dl_addr = 18'd20; bus.dl_data = 8'h66;
        tick;
        bus.dl_wr = 1'b0;
        chk("ovf_set", 32'(bus.dl_overflow), 32'd1);
        tick; tick;
        ref_mem[10] = 8'h55; ref_len = 11;
        end_dl;
        chk("ovf_wren_cnt", 32'(wren_q.size()), 32'd1);
        do_read(18'd10, d, e, lat);
        chk("ovf_rd10", 32'(d), 32'h55);
        do_read(18'd20, d, e, lat);
        chk("ovf_rd20_eof", 32'(e), 32'd1);
        chk("ovf_sticky", 32'(bus.dl_overflow), 32'd1);

        // Randomized download and reads against the reference image.
        start_dl;
        for (int i = 0; i < 30; i++) begin
            dl_write(18'($urandom_range(0, 255)), 8'($urandom));
            repeat ($urandom_range(0, 2)) tick;
        end
        end_dl;
        for (int i = 0; i < 40; i++) begin
            a0 = int'($urandom_range(0, 299));
            do_read(18'(a0), d, e, lat);
            if (a0 >= ref_len) begin
                chk("rnd_eof", 32'(e), 32'd1);
                chk("rnd_eof_data", 32'(d), 32'hFF);
                chk("rnd_eof_lat", 32'(lat), 32'd1);
            end else begin
                chk("rnd_eof", 32'(e), 32'd0);
                chk("rnd_data", 32'(d), 32'(ref_byte(a0)));
                chk("rnd_lat", 32'(lat), 32'd3);
            end
        end

        // Top address: length needs the extra bit.
        start_dl;
        dl_write(18'h3FFFF, 8'h77);
        end_dl;
        chk("top_len", 32'(bus.cas_len), 32'h40000);
        do_read(18'h3FFFF, d, e, lat);
        chk("top_rd_data", 32'(d), 32'h77);
        chk("top_rd_eof", 32'(e), 32'd0);

        // Re-raise download: image cleared, reads stall until commit.
        bus.dl_active = 1'b1;
        tick;
        ref_len = 0;
        chk("rerise_len", 32'(bus.cas_len), 32'd0);
        chk("rerise_valid", 32'(bus.cas_valid), 32'd0);
        a0 = ack_cnt;
        bus.rd_addr = 18'd0; bus.rd_req = 1'b1;
        repeat (6) tick;
        chk("stall_no_ack", 32'(ack_cnt - a0), 32'd0);
        d0 = done_cnt;
        bus.dl_active = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            tick;
            if (bus.rd_ack) begin
                lat = i;
                chk("resume_eof", 32'(bus.rd_eof), 32'd1);
                chk("resume_after_done", 32'(done_cnt - d0), 32'd1);
            end
        end
        bus.rd_req = 1'b0;
        chk("resume_ack_seen", 32'(lat != 0), 32'd1);
        tick;

        // Reset in the middle of a RAM read: ack is lost, outputs clear at once.
        start_dl;
        dl_write(18'd5, 8'h5A);
        end_dl;
        bus.rd_addr = 18'd5; bus.rd_req = 1'b1;
        tick; tick;
        a0 = ack_cnt;
        reset = 1'b1;
        bus.rd_req = 1'b0;
        #1;
        check_outputs_zero("midrd");
        tick; tick;
        reset = 1'b0;
        ref_len = 0;
        repeat (4) tick;
        chk("midrd_no_ack", 32'(ack_cnt - a0), 32'd0);
        do_read(18'd5, d, e, lat);
        chk("post_rst_lat", 32'(lat), 32'd1);
        chk("post_rst_eof", 32'(e), 32'd1);
        chk("post_rst_data", 32'(d), 32'hFF);

        chk("wren_during_rd", 32'(wren_in_rd), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/cas_ram_arbiter.md
Name: cas_ram_arbiter

Overview:
Shares the single-port 256 KiB cassette image RAM between the HPS download writer (CAS file load via ioctl) and the tape playback reader. It serialises writes and reads, back-pressures the downloader with dl_wait, and tracks the loaded image length. Reads past that length return an end-of-tape flag without touching RAM. It sits between hps_io, the tape player and the CAS spram in the emu top level, replacing the current address/wren muxing.

Parameters:
AW, 18, RAM address width in bytes (image capacity 2^AW).
RD_LATENCY, 1, cycles from ram_addr presented to ram_q valid (1..3).

Ports:
clk  in  1  system clock (clk_sys)
reset  in  1  asynchronous, active-high reset
dl_active  in  1  CAS download in progress (ioctl_download && CAS index)
dl_wr  in  1  one-cycle write strobe from downloader
dl_addr  in  AW  download byte address
dl_data  in  8  download byte
dl_wait  out  1  downloader must not strobe dl_wr while high
dl_done  out  1  one-cycle pulse when a download has fully committed
dl_overflow  out  1  sticky: dl_wr seen while hold register full
rd_req  in  1  level read request from tape player, held until rd_ack
rd_addr  in  AW  read byte address, stable while rd_req high
rd_ack  out  1  one-cycle read completion
rd_data  out  8  read byte, valid with rd_ack
rd_eof  out  1  valid with rd_ack: rd_addr >= cas_len
cas_len  out  AW+1  committed image length in bytes
cas_valid  out  1  image loaded and complete
ram_addr  out  AW  RAM address (registered)
ram_wren  out  1  RAM write enable (registered, one cycle per byte)
ram_data  out  8  RAM write data (registered)
ram_q  in  8  RAM read data

Behaviour:
- Reset (async): all outputs 0. rd_data=8'h00, cas_len=0, state IDLE, hold register empty, in-flight read dropped with no rd_ack.
- States: IDLE, WRITE, READ (latency counter), DONE.
- Hold register: one entry. dl_wr in cycle T captures dl_addr/dl_data and sets hold_full; dl_wait = hold_full (registered), high from T+1.
- dl_wr with hold_full: the byte is dropped and dl_overflow is set (cleared only by reset).
- Priority: a pending write always wins over a read in IDLE.
- IDLE with hold_full: go to WRITE. ram_addr/ram_data are loaded and ram_wren=1 for exactly one cycle (T+1 when RAM idle). Hold clears in the same edge, then back to IDLE. Back-to-back writes therefore sustain 1 byte per 2 cycles.
- cas_len on each committed write: cas_len <= max(cas_len, addr+1). Computed at AW+1 bits, so addr=2^AW-1 gives 2^AW with no wrap.
- dl_active rising edge: cas_len<=0, cas_valid<=0. Any accepted-but-unacked read still completes.
- dl_active falling edge: arm commit. Once hold is empty and state is IDLE, go to DONE: cas_valid<=1, dl_done=1 for one cycle, then IDLE.
- Reads are accepted only in IDLE with hold empty, dl_active=0, rd_req=1 and rd_ack=0 in that cycle. The rd_ack=0 condition prevents a double read on the ack cycle.
- EOF read: if rd_addr >= cas_len at acceptance, the RAM is not accessed. Next cycle rd_ack=1, rd_eof=1, rd_data=8'hFF.
- Normal read: accept at T, ram_addr=rd_addr at T+1, ram_q sampled at T+1+RD_LATENCY. rd_ack=1, rd_eof=0 and rd_data=ram_q at T+2+RD_LATENCY (default: ack 3 cycles after accept).
- rd_req dropped before ack: the read still completes and acks.
- During dl_active, rd_req stalls with no ack. Reads resume after DONE.
- cas_valid=0 does not block reads; cas_len=0 makes every read EOF.
- ram_wren is never high during READ.
- ram_addr holds its last value when idle.

Test Plan:
- Reset then rd_req, rd_addr=0 → rd_ack 1 cycle after accept, rd_eof=1, rd_data=FF, ram_wren never high.
- Download of 4 bytes A0..A3 at addr 0..3 with dl_wr every 2 cycles → 4 ram_wren pulses with matching addr/data. dl_wait high 1 cycle after each strobe. On dl_active fall: dl_done one pulse, cas_valid=1, cas_len=4.
- Read addr 2 after load (RAM model, RD_LATENCY=1) → rd_ack exactly 3 cycles after accept, rd_data=A2, rd_eof=0. Read addr 4 → rd_eof=1, rd_data=FF.
- dl_wr on consecutive cycles → second byte dropped, dl_overflow=1 and stays set, cas_len reflects only the first byte.
- Write to addr 3FFFF → cas_len=40000 (19-bit) with no wrap. Re-raising dl_active → cas_len=0, cas_valid=0.
- Assert reset mid-READ (after accept, before ack) → no rd_ack, all outputs 0 immediately. A fresh read after release completes normally.
